// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute-stage sequencer: opcodes, ALU
// control encodings, FSM states, flag bit positions and the decode record.
package alu_pkg;

   // Instruction opcodes as presented by decode (7-15 are illegal)
   localparam logic [3:0] OPC_ADD = 4'd0;
   localparam logic [3:0] OPC_SUB = 4'd1;
   localparam logic [3:0] OPC_AND = 4'd2;
   localparam logic [3:0] OPC_OR  = 4'd3;
   localparam logic [3:0] OPC_NOT = 4'd4;
   localparam logic [3:0] OPC_CMP = 4'd5;
   localparam logic [3:0] OPC_NOP = 4'd6;

   // ALU op-select encodings
   localparam logic [2:0] ALU_OP_ADD = 3'b000;
   localparam logic [2:0] ALU_OP_SUB = 3'b001;
   localparam logic [2:0] ALU_OP_AND = 3'b010;
   localparam logic [2:0] ALU_OP_OR  = 3'b011;
   localparam logic [2:0] ALU_OP_NOT = 3'b100;

   // Flag bit positions within ALU_FLG / FLAGS
   localparam int FLG_NEG  = 0;
   localparam int FLG_ZERO = 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_EXEC  = 3'd1,
      ST_WB    = 3'd2,
      ST_CMP_A = 3'd3,
      ST_CMP_B = 3'd4
   } state_e;

   // Decoded view of one opcode
   typedef struct packed {
      logic [2:0] alu_op;
      logic       is_cmp;
      logic       is_nop;
      logic       is_illegal;
      logic       writes_rd;
   } dec_t;

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Bundle of the decode, ALU-control and write-back signals around the
// execute-stage sequencer. The slave modport is the sequencer's view;
// master is the surrounding pipeline / ALU / register file.
interface alu_exec_ctrl_if #(
   parameter int W     = 16,
   parameter int RDW   = 3,
   parameter int CNT_W = 16
);
   // Decode handshake
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_opc;
   logic [W-1:0]     in_d1;
   logic [W-1:0]     in_d2;
   logic [RDW-1:0]   in_rd;

   // ALU control and result
   logic             alu_en;
   logic             alu_flgon;
   logic [2:0]       alu_op;
   logic [W-1:0]     alu_d1;
   logic [W-1:0]     alu_d2;
   logic [W-1:0]     alu_res;
   logic [1:0]       alu_flg;

   // Write-back handshake
   logic             wb_valid;
   logic             wb_ready;
   logic [RDW-1:0]   wb_rd;
   logic [W-1:0]     wb_data;

   // Status
   logic [1:0]       flags;
   logic             err_ill;
   logic [CNT_W-1:0] ops_done;

   modport slave (
      input  in_valid, in_opc, in_d1, in_d2, in_rd, alu_res, alu_flg, wb_ready,
      output in_ready, alu_en, alu_flgon, alu_op, alu_d1, alu_d2,
             wb_valid, wb_rd, wb_data, flags, err_ill, ops_done
   );

   modport master (
      output in_valid, in_opc, in_d1, in_d2, in_rd, alu_res, alu_flg, wb_ready,
      input  in_ready, alu_en, alu_flgon, alu_op, alu_d1, alu_d2,
             wb_valid, wb_rd, wb_data, flags, err_ill, ops_done
   );

endinterface

// File: rtl/alu_exec_ctrl_alu_op_decode.sv
// Pure combinational opcode decoder: maps the 4-bit instruction opcode to
// the ALU op-select and the class of instruction the sequencer must run.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [3:0] opc,
   output dec_t       dec
);

   // Classify the opcode and pick the ALU op-select
   always_comb begin
      // NOTE: full default first so every path assigns every field; no latch.
      dec = '0;
      unique case (opc)
         OPC_ADD: begin dec.alu_op = ALU_OP_ADD; dec.writes_rd = 1'b1; end
         OPC_SUB: begin dec.alu_op = ALU_OP_SUB; dec.writes_rd = 1'b1; end
         OPC_AND: begin dec.alu_op = ALU_OP_AND; dec.writes_rd = 1'b1; end
         OPC_OR:  begin dec.alu_op = ALU_OP_OR;  dec.writes_rd = 1'b1; end
         OPC_NOT: begin dec.alu_op = ALU_OP_NOT; dec.writes_rd = 1'b1; end
         // Compare runs the ALU subtractor in flag mode
         OPC_CMP: begin dec.alu_op = ALU_OP_SUB; dec.is_cmp    = 1'b1; end
         OPC_NOP: dec.is_nop = 1'b1;
         default: dec.is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: accepts one decoded instruction per handshake,
// drives the combinational ALU from held operands, registers the result for
// write-back, and updates the architectural flags on CMP only.
module alu_exec_ctrl
   import alu_pkg::*;
#(
   parameter int W     = 16,
   parameter int RDW   = 3,
   parameter int CNT_W = 16
) (
   input  logic           clk,
   input  logic           rst,
   alu_exec_ctrl_if.slave bus
);

   state_e           state_q, state_d;
   logic [2:0]       alu_op_q, alu_op_d;
   logic [W-1:0]     d1_q, d1_d;
   logic [W-1:0]     d2_q, d2_d;
   logic [RDW-1:0]   rd_q, rd_d;
   logic [W-1:0]     wb_data_q, wb_data_d;
   logic [RDW-1:0]   wb_rd_q, wb_rd_d;
   logic [1:0]       flags_q, flags_d;
   logic             err_ill_q, err_ill_d;
   logic [CNT_W-1:0] ops_done_q, ops_done_d;

   dec_t dec;
   logic accept;

   alu_op_decode u_dec (
      .opc (bus.in_opc),
      .dec (dec)
   );

   assign accept = (state_q == ST_IDLE) && bus.in_valid;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               if (dec.is_cmp)         state_d = ST_CMP_A;
               else if (dec.writes_rd) state_d = ST_EXEC;
            end
         end
         ST_EXEC:  state_d = ST_WB;
         ST_WB:    if (bus.wb_ready) state_d = ST_IDLE;
         ST_CMP_A: state_d = ST_CMP_B;
         ST_CMP_B: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Hold, write-back, flag and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_op_q   <= '0;
         d1_q       <= '0;
         d2_q       <= '0;
         rd_q       <= '0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
         flags_q    <= '0;
         err_ill_q  <= 1'b0;
         ops_done_q <= '0;
      end else begin
         alu_op_q   <= alu_op_d;
         d1_q       <= d1_d;
         d2_q       <= d2_d;
         rd_q       <= rd_d;
         wb_data_q  <= wb_data_d;
         wb_rd_q    <= wb_rd_d;
         flags_q    <= flags_d;
         err_ill_q  <= err_ill_d;
         ops_done_q <= ops_done_d;
      end
   end

   // Datapath updates: capture on accept, result on EXEC exit, flags in CMP_B
   always_comb begin
      alu_op_d   = alu_op_q;
      d1_d       = d1_q;
      d2_d       = d2_q;
      rd_d       = rd_q;
      wb_data_d  = wb_data_q;
      wb_rd_d    = wb_rd_q;
      flags_d    = flags_q;
      err_ill_d  = 1'b0;
      ops_done_d = ops_done_q;

      if (accept) begin
         alu_op_d = dec.alu_op;
         d1_d     = bus.in_d1;
         d2_d     = bus.in_d2;
         rd_d     = bus.in_rd;
         if (dec.is_illegal) err_ill_d  = 1'b1;
         if (dec.is_nop)     ops_done_d = ops_done_q + CNT_W'(1);
      end

      if (state_q == ST_EXEC) begin
         wb_data_d = bus.alu_res;
         wb_rd_d   = rd_q;
      end

      if (state_q == ST_WB && bus.wb_ready)
         ops_done_d = ops_done_q + CNT_W'(1);

      if (state_q == ST_CMP_B) begin
         flags_d    = bus.alu_flg;
         ops_done_d = ops_done_q + CNT_W'(1);
      end
   end

   // Control outputs decoded from the current state
   always_comb begin
      bus.in_ready  = (state_q == ST_IDLE) && !rst;
      bus.alu_en    = (state_q == ST_EXEC) || (state_q == ST_CMP_A) ||
                      (state_q == ST_CMP_B);
      bus.alu_flgon = (state_q == ST_CMP_A) || (state_q == ST_CMP_B);
      bus.wb_valid  = (state_q == ST_WB);
   end

   // ALU operands and status come straight from registers
   assign bus.alu_op   = alu_op_q;
   assign bus.alu_d1   = d1_q;
   assign bus.alu_d2   = d2_q;
   assign bus.wb_data  = wb_data_q;
   assign bus.wb_rd    = wb_rd_q;
   assign bus.flags    = flags_q;
   assign bus.err_ill  = err_ill_q;
   assign bus.ops_done = ops_done_q;

endmodule
